// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   - PC select codes driven by the control unit
//   - program-counter FSM state encoding
//   - default reset and exception vectors
package mips_pkg;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_J   = 2'b10;
  localparam logic [1:0] PC_SEL_JR  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC calculator.
//   pc_i            current PC
//   pc_sel_i        00 seq, 01 branch, 10 jump, 11 jump-register
//   branch_taken_i  qualifies the branch select
//   imm16_i         branch offset in words (signed)
//   jtarget_i       J-format target field
//   jr_addr_i       register target for jr
//   next_pc_o       selected target (ignores misalignment)
//   pc_plus4_o      pc_i + 4, modulo 2^WIDTH
//   jr_misaligned_o jr selected with a non-word-aligned target
module pc_next_calc
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [1:0]       pc_sel_i,
  input  logic             branch_taken_i,
  input  logic [15:0]      imm16_i,
  input  logic [25:0]      jtarget_i,
  input  logic [WIDTH-1:0] jr_addr_i,
  output logic [WIDTH-1:0] next_pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             jr_misaligned_o
);

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(32'd4);

  logic [WIDTH-1:0] br_offset;

  assign pc_plus4_o = pc_i + FOUR;

  // Word offset -> byte offset, sign-extended to the full PC width.
  assign br_offset = {{(WIDTH-18){imm16_i[15]}}, imm16_i, 2'b00};

  assign jr_misaligned_o = (pc_sel_i == PC_SEL_JR) && (jr_addr_i[1:0] != 2'b00);

  // NOTE: assign a default before the case so every path drives next_pc_o; otherwise a latch is inferred.
  always_comb begin
    next_pc_o = pc_plus4_o;
    unique case (pc_sel_i)
      PC_SEL_SEQ: next_pc_o = pc_plus4_o;
      PC_SEL_BR:  next_pc_o = branch_taken_i ? (pc_plus4_o + br_offset) : pc_plus4_o;
      // Jump keeps the region bits of the delay-slot address.
      PC_SEL_J:   next_pc_o = {pc_plus4_o[WIDTH-1:28], jtarget_i, 2'b00};
      PC_SEL_JR:  next_pc_o = jr_addr_i;
      default:    next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, run/halt FSM, exception redirect with
// EPC capture and misaligned-jr detection.
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   stall_i        hold PC (exceptions and halt still act)
//   halt_req_i     enter HALT after this cycle's update
//   resume_i       leave HALT
//   pc_sel_i, branch_taken_i, imm16_i, jtarget_i, jr_addr_i  target selection
//   exc_req_i      synchronous exception request
//   pc_out_o       current PC (imem address)
//   pc_plus4_o     pc_out_o + 4, combinational (jal link)
//   fetch_valid_o  pc_out_o is fetchable (RUN state)
//   epc_o          PC of the faulting instruction
//   misaligned_o   one-cycle pulse after a misaligned jr redirect
//   halted_o       FSM is in HALT
module pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  input  logic [1:0]       pc_sel_i,
  input  logic             branch_taken_i,
  input  logic [15:0]      imm16_i,
  input  logic [25:0]      jtarget_i,
  input  logic [WIDTH-1:0] jr_addr_i,
  input  logic             exc_req_i,
  output logic [WIDTH-1:0] pc_out_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             fetch_valid_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             misaligned_o,
  output logic             halted_o
);

  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_VECTOR);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             misaligned_q, misaligned_d;

  logic [WIDTH-1:0] next_pc;
  logic             jr_misaligned;

  pc_next_calc #(
    .WIDTH (WIDTH)
  ) u_next (
    .pc_i            (pc_q),
    .pc_sel_i        (pc_sel_i),
    .branch_taken_i  (branch_taken_i),
    .imm16_i         (imm16_i),
    .jtarget_i       (jtarget_i),
    .jr_addr_i       (jr_addr_i),
    .next_pc_o       (next_pc),
    .pc_plus4_o      (pc_plus4_o),
    .jr_misaligned_o (jr_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (exc_req_i) begin
          pc_d  = EXC_VEC;
          epc_d = pc_q;
        end else if (jr_misaligned) begin
          // A bad jr target traps even when stalled.
          pc_d         = EXC_VEC;
          epc_d        = pc_q;
          misaligned_d = 1'b1;
        end else if (!stall_i) begin
          pc_d = next_pc;
        end
        if (halt_req_i) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (exc_req_i) begin
          pc_d    = EXC_VEC;
          epc_d   = pc_q;
          state_d = ST_RUN;
        end else if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RST_VEC;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_out_o      = pc_q;
  assign epc_o         = epc_q;
  assign misaligned_o  = misaligned_q;
  assign fetch_valid_o = (state_q == ST_RUN);
  assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (WIDTH=32, default vectors).
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge after each rising edge. Expected results travel through a
// scoreboard queue from stimulus to comparison.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall, halt_req, resume, branch_taken, exc_req;
  logic [1:0]  pc_sel;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] jr_addr;
  logic [31:0] pc_out, pc_plus4, epc;
  logic        fetch_valid, misaligned, halted;

  pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .halt_req_i     (halt_req),
    .resume_i       (resume),
    .pc_sel_i       (pc_sel),
    .branch_taken_i (branch_taken),
    .imm16_i        (imm16),
    .jtarget_i      (jtarget),
    .jr_addr_i      (jr_addr),
    .exc_req_i      (exc_req),
    .pc_out_o       (pc_out),
    .pc_plus4_o     (pc_plus4),
    .fetch_valid_o  (fetch_valid),
    .epc_o          (epc),
    .misaligned_o   (misaligned),
    .halted_o       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] epc;
    logic        fv;
    logic        mis;
    logic        hlt;
  } obs_t;

  typedef struct {
    string       name;
    logic        stall, halt_req, resume, bt, exc;
    logic [1:0]  sel;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] jr;
    obs_t        exp;
  } vec_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  // Expected outputs in RUN or HALT; fetch_valid follows the state.
  function automatic obs_t ex(logic [31:0] pc, logic [31:0] e, logic mis, logic hlt);
    obs_t o;
    o.pc  = pc;
    o.p4  = pc + 32'd4;
    o.epc = e;
    o.fv  = ~hlt;
    o.mis = mis;
    o.hlt = hlt;
    return o;
  endfunction

  function automatic obs_t boot_obs();
    obs_t o;
    o     = ex(32'h0, 32'h0, 1'b0, 1'b0);
    o.fv  = 1'b0;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.pc  = pc_out;
    o.p4  = pc_plus4;
    o.epc = epc;
    o.fv  = fetch_valid;
    o.mis = misaligned;
    o.hlt = halted;
    return o;
  endfunction

  function automatic vec_t base(string name, obs_t exp);
    vec_t v;
    v.name = name;
    v.stall = 0; v.halt_req = 0; v.resume = 0; v.bt = 0; v.exc = 0;
    v.sel = 2'b00; v.imm = '0; v.jt = '0; v.jr = '0;
    v.exp = exp;
    return v;
  endfunction

  function automatic vec_t vjr(string name, logic [31:0] a, obs_t exp);
    vec_t v;
    v = base(name, exp);
    v.sel = 2'b11;
    v.jr  = a;
    return v;
  endfunction

  function automatic vec_t vbr(string name, logic bt, logic [15:0] imm, obs_t exp);
    vec_t v;
    v = base(name, exp);
    v.sel = 2'b01;
    v.bt  = bt;
    v.imm = imm;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    stall = v.stall; halt_req = v.halt_req; resume = v.resume;
    branch_taken = v.bt; exc_req = v.exc; pc_sel = v.sel;
    imm16 = v.imm; jtarget = v.jt; jr_addr = v.jr;
  endtask

  task automatic test_reset();
    vec_t v[$];
    sb_t  s;
    obs_t got;
    apply(base("idle", boot_obs()));
    rst = 1'b1;
    #2;
    sb_q.push_back('{"reset_held", boot_obs()});
    got = observe(); s = sb_q.pop_front(); checks++;
    if (got !== s.exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb_q.push_back('{"boot_cycle", boot_obs()});
    got = observe(); s = sb_q.pop_front(); checks++;
    if (got !== s.exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
    end
    v.push_back(base("boot_to_run", ex(32'h0, 0, 0, 0)));
    v.push_back(base("seq_4",       ex(32'h4, 0, 0, 0)));
    v.push_back(base("seq_8",       ex(32'h8, 0, 0, 0)));
    foreach (v[i]) begin
      apply(v[i]);
      sb_q.push_back('{v[i].name, v[i].exp});
      @(posedge clk); @(negedge clk);
      got = observe(); s = sb_q.pop_front(); checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[$];
    sb_t  s;
    obs_t got;
    v.push_back(vjr("br_setup",    32'h100, ex(32'h100, 0, 0, 0)));
    v.push_back(vbr("br_back",     1, 16'hFFFE, ex(32'h0FC, 0, 0, 0)));
    v.push_back(vbr("br_not_taken",0, 16'h0003, ex(32'h100, 0, 0, 0)));
    v.push_back(vbr("br_max_fwd",  1, 16'h7FFF, ex(32'h0002_0100, 0, 0, 0)));
    v.push_back(vjr("jr_top",      32'hFFFF_FFFC, ex(32'hFFFF_FFFC, 0, 0, 0)));
    v.push_back(base("seq_wrap",   ex(32'h0, 0, 0, 0)));
    v.push_back(vbr("br_wrap_neg", 1, 16'hFFFE, ex(32'hFFFF_FFFC, 0, 0, 0)));
    foreach (v[i]) begin
      apply(v[i]);
      sb_q.push_back('{v[i].name, v[i].exp});
      @(posedge clk); @(negedge clk);
      got = observe(); s = sb_q.pop_front(); checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_jump();
    vec_t v[$];
    vec_t t;
    sb_t  s;
    obs_t got;
    v.push_back(vjr("j_setup", 32'h3000_0010, ex(32'h3000_0010, 0, 0, 0)));
    t = base("j_region", ex(32'h3000_0100, 0, 0, 0)); t.sel = 2'b10; t.jt = 26'h000_0040;
    v.push_back(t);
    v.push_back(vjr("jr_misaligned", 32'h0000_0202, ex(32'h80, 32'h3000_0100, 1, 0)));
    v.push_back(base("mis_pulse_end", ex(32'h84, 32'h3000_0100, 0, 0)));
    t = vjr("exc_over_mis", 32'h0000_0203, ex(32'h80, 32'h84, 0, 0)); t.exc = 1;
    v.push_back(t);
    foreach (v[i]) begin
      apply(v[i]);
      sb_q.push_back('{v[i].name, v[i].exp});
      @(posedge clk); @(negedge clk);
      got = observe(); s = sb_q.pop_front(); checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_stall();
    vec_t v[$];
    vec_t t;
    sb_t  s;
    obs_t got;
    v.push_back(vjr("st_setup", 32'h40, ex(32'h40, 32'h84, 0, 0)));
    t = base("stall_1", ex(32'h40, 32'h84, 0, 0)); t.stall = 1; v.push_back(t);
    t = base("stall_2", ex(32'h40, 32'h84, 0, 0)); t.stall = 1; v.push_back(t);
    t = vbr("stall_br", 1, 16'h0010, ex(32'h40, 32'h84, 0, 0)); t.stall = 1; v.push_back(t);
    t = base("stall_exc", ex(32'h80, 32'h40, 0, 0)); t.stall = 1; t.exc = 1; v.push_back(t);
    v.push_back(vjr("st_setup2", 32'h44, ex(32'h44, 32'h40, 0, 0)));
    t = vjr("stall_mis", 32'h41, ex(32'h80, 32'h44, 1, 0)); t.stall = 1; v.push_back(t);
    t = base("stall_after_mis", ex(32'h80, 32'h44, 0, 0)); t.stall = 1; v.push_back(t);
    foreach (v[i]) begin
      apply(v[i]);
      sb_q.push_back('{v[i].name, v[i].exp});
      @(posedge clk); @(negedge clk);
      got = observe(); s = sb_q.pop_front(); checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_halt();
    vec_t v[$];
    vec_t t;
    sb_t  s;
    obs_t got;
    v.push_back(vjr("h_setup", 32'h20, ex(32'h20, 32'h44, 0, 0)));
    t = base("halt_enter", ex(32'h24, 32'h44, 0, 1)); t.halt_req = 1; v.push_back(t);
    t = base("halt_j", ex(32'h24, 32'h44, 0, 1)); t.sel = 2'b10; t.jt = 26'h123; v.push_back(t);
    t = base("halt_stall", ex(32'h24, 32'h44, 0, 1)); t.stall = 1; v.push_back(t);
    v.push_back(vjr("halt_bad_jr", 32'h3, ex(32'h24, 32'h44, 0, 1)));
    t = base("halt_req_again", ex(32'h24, 32'h44, 0, 1)); t.halt_req = 1; v.push_back(t);
    v.push_back(vbr("halt_br", 1, 16'h0008, ex(32'h24, 32'h44, 0, 1)));
    t = base("resume", ex(32'h24, 32'h44, 0, 0)); t.resume = 1; v.push_back(t);
    v.push_back(base("after_resume", ex(32'h28, 32'h44, 0, 0)));
    t = base("halt_again", ex(32'h2C, 32'h44, 0, 1)); t.halt_req = 1; v.push_back(t);
    t = base("resume_wins", ex(32'h2C, 32'h44, 0, 0)); t.resume = 1; t.halt_req = 1; v.push_back(t);
    t = base("halt_exc_run", ex(32'h80, 32'h2C, 0, 1)); t.halt_req = 1; t.exc = 1; v.push_back(t);
    t = base("resume2", ex(32'h80, 32'h2C, 0, 0)); t.resume = 1; v.push_back(t);
    t = vbr("halt_with_br", 1, 16'h0001, ex(32'h88, 32'h2C, 0, 1)); t.halt_req = 1; v.push_back(t);
    t = base("exc_in_halt", ex(32'h80, 32'h88, 0, 0)); t.exc = 1; v.push_back(t);
    foreach (v[i]) begin
      apply(v[i]);
      sb_q.push_back('{v[i].name, v[i].exp});
      @(posedge clk); @(negedge clk);
      got = observe(); s = sb_q.pop_front(); checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t t;
    sb_t  s;
    obs_t got;
    t = vjr("ar_setup", 32'h20, ex(32'h20, 32'h88, 0, 1)); t.halt_req = 1;
    apply(t);
    sb_q.push_back('{t.name, t.exp});
    @(posedge clk); @(negedge clk);
    got = observe(); s = sb_q.pop_front(); checks++;
    if (got !== s.exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
    end
    apply(base("idle", boot_obs()));
    #2 rst = 1'b1;
    #1;
    sb_q.push_back('{"async_reset_midcycle", boot_obs()});
    got = observe(); s = sb_q.pop_front(); checks++;
    if (got !== s.exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back('{"run_after_reset", ex(32'h0, 32'h0, 0, 0)});
    @(posedge clk); @(negedge clk);
    got = observe(); s = sb_q.pop_front(); checks++;
    if (got !== s.exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", s.name, got, s.exp);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_halt();
    test_async_reset();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle MIPS core.
- Holds the PC register and computes PC+4, branch, jump and jump-register targets internally.
- Adds stall, halt/resume, exception redirect with EPC capture, and misaligned-jump detection.
- Sits between control/ALU outputs and instruction memory; pc_out drives the imem address.

Parameters:
- WIDTH, 32, PC width in bits; legal range 32..64.
- RESET_VECTOR, 32'h0000_0000, PC value after reset (zero-extended to WIDTH).
- EXC_VECTOR, 32'h0000_0080, redirect target on exception or misaligned jr (zero-extended).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC; no state change except exception/halt.
- halt_req  in  1  enter HALT after the current update.
- resume  in  1  leave HALT.
- pc_sel  in  2  00 seq, 01 branch, 10 jump, 11 jump-register.
- branch_taken  in  1  qualifies pc_sel=01.
- imm16  in  16  branch offset in words.
- jtarget  in  26  J-format target field.
- jr_addr  in  WIDTH  register target for jr.
- exc_req  in  1  synchronous exception request.
- pc_out  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc_out+4, combinational; used for jal link.
- fetch_valid  out  1  pc_out is a fetchable instruction address.
- epc  out  WIDTH  PC of the faulting instruction.
- misaligned  out  1  one-cycle pulse: jr target not word-aligned.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (async, any time, including mid-halt or mid-stall): pc_out=RESET_VECTOR, epc=0, misaligned=0, state=BOOT, fetch_valid=0, halted=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: PC holds; next edge goes to RUN. fetch_valid is low for exactly one cycle after reset release.
  - RUN: fetch_valid=1. PC updates each edge per the priority below.
  - HALT: PC holds; fetch_valid=0; halted=1; stall and pc_sel are ignored.
- Update priority in RUN, highest first:
  1. exc_req: PC<=EXC_VECTOR, epc<=pc_out.
  2. pc_sel=11 with jr_addr[1:0]!=0: PC<=EXC_VECTOR, epc<=pc_out, misaligned pulses 1 the next cycle.
  3. stall: PC holds.
  4. Normal select:
     - 00, or 01 with branch_taken=0: pc_plus4.
     - 01 with branch_taken=1: pc_plus4 + (sign-extended imm16 << 2).
     - 10: {pc_plus4[WIDTH-1:28], jtarget, 2'b00}.
     - 11 (aligned): jr_addr.
- Halt:
  - halt_req in RUN: the update for that cycle still occurs (exc_req still wins), then the FSM enters HALT.
  - resume in HALT: next edge returns to RUN; PC is unchanged by the transition.
  - exc_req in HALT: PC<=EXC_VECTOR, epc<=pc_out, FSM goes to RUN.
  - resume and halt_req both high in HALT: go to RUN (resume wins).
- Arithmetic: all adds are modulo 2^WIDTH; wrap-around is silent, with no flag.
- misaligned: registered; high for exactly one cycle per offending event.
- epc: changes only on an exception or misaligned redirect.

Decomposition:
- Shared package mips_pkg:
  - PC_SEL_SEQ, PC_SEL_BR, PC_SEL_J, PC_SEL_JR localparams.
  - FSM state encoding (BOOT=0, RUN=1, HALT=2).
  - Default vectors.
- One natural sub-module, pc_next_calc: purely combinational target mux and adders (pc, pc_sel, branch_taken, imm16, jtarget, jr_addr -> next_pc, pc_plus4, jr_misaligned).
- pc_unit keeps the registers and FSM.

Test Plan:
- Reset then 3 idle cycles with pc_sel=00 -> pc_out 0, 0 (BOOT, fetch_valid=0), 4, 8; fetch_valid rises on the second cycle.
- From pc=0x100: branch_taken=1, imm16=0xFFFE -> pc=0x0FC. Then imm16=0x0003, branch_taken=0 -> pc=0x100.
- From pc=0x3000_0010: pc_sel=10, jtarget=0x000_0040 -> pc=0x3000_0100. Then pc_sel=11, jr_addr=0x0000_0202 -> pc=0x80, epc=0x3000_0100, one-cycle misaligned pulse.
- From pc=0x40: stall=1 for 2 cycles -> pc holds 0x40. Then stall and exc_req both high -> pc=0x80, epc=0x40.
- From pc=0x20: halt_req=1 -> pc=0x24, halted=1, fetch_valid=0. 5 cycles -> pc=0x24. resume=1 -> RUN, next update gives 0x28.
- From pc=0x20 with FSM in HALT: assert rst asynchronously mid-cycle -> pc_out=0, halted=0 immediately, without waiting for a clock edge.
